joypad_responder: RTL and testbench
===================================

Name: joypad_responder

Overview:
- CPU-bus responder for the NES controller registers $4016 (write strobe, read port 0) and $4017 (read port 1).
- Sits on the CPU data/address bus alongside RAM and PPU decode, and answers the accesses the CPU issues.
- A background scanner serially polls two physical 4021-style pads into a shadow state.
- CPU reads shift that state out one button per read, with NES-accurate strobe semantics.

Parameters:
- LATCH_CLKS, 12: clocks pad_latch is held high per scan.
- HALF_CLKS, 6: clocks per pad_clk half-period.
- POLL_CLKS, 20'd357954: clocks from the start of one scan to the start of the next (about 60 Hz at 21.477 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU address bus
- cpu_wdata  in  8  CPU write data
- cpu_rnw  in  1  1=read, 0=write
- cpu_cyc  in  1  one-clock pulse marking the commit clock of a CPU bus cycle
- cpu_rdata  out  8  read data to CPU
- cpu_rd_valid  out  1  one-clock pulse: cpu_rdata valid, this block drives the bus
- pad_latch  out  1  parallel-load strobe to both pads
- pad_clk  out  1  shift clock to both pads
- pad_data  in  2  serial data from pad1/pad0, active-low (0 = pressed)
- strobe_dbg  out  1  current strobe bit

Behaviour:
- Reset (async, rst=1):
  - strobe=0.
  - pad_state[1:0] = 8'h00 each.
  - shift regs = 8'h00.
  - cpu_rdata = 8'h00, cpu_rd_valid=0.
  - pad_latch=0, pad_clk=0.
  - Scanner enters IDLE with poll counter 0.
- Write hit (cpu_cyc & !cpu_rnw & addr==16'h4016): strobe <= cpu_wdata[0]. Writes to $4017 and all other addresses are ignored.
- Strobe=1: every clock, shift0 <= pad_state0 and shift1 <= pad_state1. Strobe 1->0 freezes the last loaded value; no explicit edge logic is needed.
- Read hit (cpu_cyc & cpu_rnw & addr==16'h4016 or 16'h4017), registered, latency 1 clock:
  - cpu_rdata <= {3'b010, 4'b0000, shiftN[0]}. Bits 7:5 model open bus $40.
  - cpu_rd_valid pulses for 1 clock.
  - If strobe=0: shiftN <= {1'b1, shiftN[7:1]}, so reads 9+ return bit0=1.
  - If strobe=1: no shift; bit0 always reflects button A.
  - Only the addressed port shifts.
- Non-hit cycles: cpu_rd_valid=0 and cpu_rdata holds its last value.
- Button order in the shift regs (bit0..7): A, B, Select, Start, Up, Down, Left, Right.
- Scanner FSM (states IDLE, LATCH, SAMPLE, CLK_HI, CLK_LO, COMMIT):
  - IDLE: poll counter counts up; at POLL_CLKS-1 go to LATCH and reset the counter. The counter runs through all states, so the period is exact.
  - LATCH: pad_latch=1 for LATCH_CLKS clocks, then SAMPLE with bit index 0.
  - SAMPLE (1 clock): work0[idx] <= ~pad_data[0], work1[idx] <= ~pad_data[1]. If idx==7 go to COMMIT, else CLK_HI.
  - CLK_HI: pad_clk=1 for HALF_CLKS clocks. CLK_LO: pad_clk=0 for HALF_CLKS clocks, then idx++ and go to SAMPLE.
  - COMMIT (1 clock): pad_state <= work, then IDLE.
- pad_latch and pad_clk are registered outputs, glitch-free, and never high simultaneously.
- A COMMIT in the same clock as a strobe=1 reload: the shift reg loads the old pad_state; the new value arrives next clock.
- A CPU read in the same clock as COMMIT is unaffected: the shift reg is independent of the scanner.
- Reset mid-scan: outputs drop immediately and pad_state clears. After release, the first scan starts POLL_CLKS clocks later.
- Widths:
  - The poll counter is 20 bits; POLL_CLKS must exceed the scan length LATCH_CLKS+8+14*HALF_CLKS+1.
  - The phase counter is sized by $clog2 of max(LATCH_CLKS, HALF_CLKS).

Decomposition:
- Package joypad_pkg holds:
  - address constants JOY0_ADDR=16'h4016 and JOY1_ADDR=16'h4017;
  - OPEN_BUS_HI=3'b010;
  - the scanner state enum;
  - button bit-index constants.
- Sub-module joypad_scanner: owns the FSM and counters, and outputs pad_state0/1 plus pad_latch and pad_clk.
- The top level holds bus decode, strobe and shift regs.

Test Plan:
- Reset check: assert rst mid-LATCH -> pad_latch=0, pad_clk=0, cpu_rd_valid=0 and cpu_rdata=8'h00 immediately. A read of $4016 before any scan returns 8'h40.
- Pad0 data for A+Start pressed (serial 0,1,1,0,1,1,1,1), let one scan COMMIT, write $4016=1 then 0, read $4016 x10 -> 41,40,40,41,40,40,40,40,41,41.
- Strobe held at 1 with A pressed, read $4016 x3 -> 41,41,41. Release strobe, then read B -> 40.
- Pad1 = Right only, pad0 = none, read $4017 x8 -> bit0 high only on the 8th read. Interleaved $4016 reads do not disturb the $4017 sequence.
- Write $4017=1 -> strobe unchanged: strobe_dbg stays 0 and shifting continues.
- Pad_latch timing with LATCH_CLKS=12, HALF_CLKS=6: first pad_latch rise at clock POLL_CLKS after reset, high for 12 clocks. Exactly 7 pad_clk pulses of 6 clocks each, then pad_state updates once.

Source files
------------

// File: rtl/joypad_pkg.sv
// Shared constants and types for the NES controller port responder.
package joypad_pkg;

    localparam logic [15:0] JOY0_ADDR   = 16'h4016;
    localparam logic [15:0] JOY1_ADDR   = 16'h4017;
    localparam logic [2:0]  OPEN_BUS_HI = 3'b010;

    // Bit positions of each button in the pad state / shift registers.
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSample,
        StClkHi,
        StClkLo,
        StCommit
    } scan_state_e;

endpackage

// File: rtl/joypad_scanner.sv
// Background poller: latches both 4021-style pads, clocks out 8 bits each and
// commits the active-high button state once per poll period.
module joypad_scanner
    import joypad_pkg::*;
#(
    parameter int unsigned LATCH_CLKS = 12,
    parameter int unsigned HALF_CLKS  = 6,
    parameter logic [19:0] POLL_CLKS  = 20'd357954
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_pad_data,
    output logic [7:0] o_pad_state0,
    output logic [7:0] o_pad_state1,
    output logic       o_pad_latch,
    output logic       o_pad_clk
);

    localparam int unsigned PhMax = (LATCH_CLKS > HALF_CLKS) ? LATCH_CLKS : HALF_CLKS;
    localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

    scan_state_e      r_state, w_state_d;
    logic [19:0]      r_poll;
    logic [PhW-1:0]   r_phase, w_phase_d;
    logic [2:0]       r_idx, w_idx_d;
    logic [7:0]       r_work0, r_work1;
    logic [7:0]       r_state0, r_state1;
    logic             r_latch, r_clk;
    logic             w_poll_wrap;

    // The poll counter free-runs across all states so the scan period is exact.
    assign w_poll_wrap = (r_poll == POLL_CLKS - 20'd1);

    always_comb begin
        w_state_d = r_state;
        w_phase_d = r_phase;
        w_idx_d   = r_idx;
        case (r_state)
            StIdle: begin
                if (w_poll_wrap) begin
                    w_state_d = StLatch;
                    w_phase_d = '0;
                end
            end
            StLatch: begin
                if (r_phase == PhW'(LATCH_CLKS - 1)) begin
                    w_state_d = StSample;
                    w_phase_d = '0;
                    w_idx_d   = '0;
                end else begin
                    w_phase_d = r_phase + 1'b1;
                end
            end
            StSample: begin
                w_phase_d = '0;
                w_state_d = (r_idx == 3'(BTN_RIGHT)) ? StCommit : StClkHi;
            end
            StClkHi: begin
                if (r_phase == PhW'(HALF_CLKS - 1)) begin
                    w_state_d = StClkLo;
                    w_phase_d = '0;
                end else begin
                    w_phase_d = r_phase + 1'b1;
                end
            end
            StClkLo: begin
                if (r_phase == PhW'(HALF_CLKS - 1)) begin
                    w_state_d = StSample;
                    w_phase_d = '0;
                    w_idx_d   = r_idx + 3'd1;
                end else begin
                    w_phase_d = r_phase + 1'b1;
                end
            end
            StCommit: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_poll   <= '0;
            r_phase  <= '0;
            r_idx    <= '0;
            r_work0  <= '0;
            r_work1  <= '0;
            r_state0 <= '0;
            r_state1 <= '0;
            r_latch  <= 1'b0;
            r_clk    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_poll  <= w_poll_wrap ? 20'd0 : r_poll + 20'd1;
            r_phase <= w_phase_d;
            r_idx   <= w_idx_d;
            if (r_state == StSample) begin
                r_work0[r_idx] <= ~i_pad_data[0];
                r_work1[r_idx] <= ~i_pad_data[1];
            end
            if (r_state == StCommit) begin
                r_state0 <= r_work0;
                r_state1 <= r_work1;
            end
            // Decoded from next state so both strobes are clean registered outputs.
            r_latch <= (w_state_d == StLatch);
            r_clk   <= (w_state_d == StClkHi);
        end
    end

    assign o_pad_state0 = r_state0;
    assign o_pad_state1 = r_state1;
    assign o_pad_latch  = r_latch;
    assign o_pad_clk    = r_clk;

endmodule

// File: rtl/joypad_responder.sv
// CPU-bus responder for $4016/$4017: strobe register, per-port shift registers
// and registered read data, fed by the background pad scanner.
module joypad_responder
    import joypad_pkg::*;
#(
    parameter int unsigned LATCH_CLKS = 12,
    parameter int unsigned HALF_CLKS  = 6,
    parameter logic [19:0] POLL_CLKS  = 20'd357954
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rnw,
    input  logic        cpu_cyc,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rd_valid,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [1:0]  pad_data,
    output logic        strobe_dbg
);

    logic [7:0] w_state0, w_state1;
    logic       w_wr_hit, w_rd0, w_rd1;
    logic       w_unused_wdata;
    logic       r_strobe;
    logic [7:0] r_shift0, r_shift1;
    logic [7:0] r_rdata;
    logic       r_rd_valid;

    joypad_scanner #(
        .LATCH_CLKS (LATCH_CLKS),
        .HALF_CLKS  (HALF_CLKS),
        .POLL_CLKS  (POLL_CLKS)
    ) u_scanner (
        .clk          (clk),
        .rst          (rst),
        .i_pad_data   (pad_data),
        .o_pad_state0 (w_state0),
        .o_pad_state1 (w_state1),
        .o_pad_latch  (pad_latch),
        .o_pad_clk    (pad_clk)
    );

    assign w_wr_hit       = cpu_cyc & ~cpu_rnw & (cpu_addr == JOY0_ADDR);
    assign w_rd0          = cpu_cyc & cpu_rnw & (cpu_addr == JOY0_ADDR);
    assign w_rd1          = cpu_cyc & cpu_rnw & (cpu_addr == JOY1_ADDR);
    assign w_unused_wdata = ^cpu_wdata[7:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe   <= 1'b0;
            r_shift0   <= '0;
            r_shift1   <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_strobe <= cpu_wdata[0];
            end
            r_rd_valid <= w_rd0 | w_rd1;
            if (w_rd0) begin
                r_rdata <= {OPEN_BUS_HI, 4'b0000, r_shift0[BTN_A]};
            end else if (w_rd1) begin
                r_rdata <= {OPEN_BUS_HI, 4'b0000, r_shift1[BTN_A]};
            end
            // While strobed the shifters track pad state every clock; 1->0 freezes them.
            if (r_strobe) begin
                r_shift0 <= w_state0;
                r_shift1 <= w_state1;
            end else begin
                if (w_rd0) r_shift0 <= {1'b1, r_shift0[7:1]};
                if (w_rd1) r_shift1 <= {1'b1, r_shift1[7:1]};
            end
        end
    end

    assign cpu_rdata    = r_rdata;
    assign cpu_rd_valid = r_rd_valid;
    assign strobe_dbg   = r_strobe;

endmodule

// File: tb/tb_joypad_responder.sv
// Directed bench for joypad_responder with a behavioural 4021 pad model per port.
module tb_joypad_responder;

    localparam int POLL = 300;
    localparam int LATCH = 12;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rnw = 1'b1;
    logic        cpu_cyc = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rd_valid;
    logic        pad_latch;
    logic        pad_clk;
    logic [1:0]  pad_data;
    logic        strobe_dbg;

    int n_checks = 0;
    int n_fail = 0;

    joypad_responder #(
        .LATCH_CLKS (LATCH),
        .HALF_CLKS  (HALF),
        .POLL_CLKS  (20'(POLL))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rnw      (cpu_rnw),
        .cpu_cyc      (cpu_cyc),
        .cpu_rdata    (cpu_rdata),
        .cpu_rd_valid (cpu_rd_valid),
        .pad_latch    (pad_latch),
        .pad_clk      (pad_clk),
        .pad_data     (pad_data),
        .strobe_dbg   (strobe_dbg)
    );

    always #5 clk = ~clk;

    // Pad model: pressed buttons (1 = pressed), serial output active-low, A first.
    logic [7:0] btn0 = '0;
    logic [7:0] btn1 = '0;
    logic [7:0] sh0 = 8'hFF;
    logic [7:0] sh1 = 8'hFF;
    logic       pclk_prev = 1'b0;

    always @(posedge clk) begin
        if (pad_latch) begin
            sh0 <= ~btn0;
            sh1 <= ~btn1;
        end else if (pad_clk && !pclk_prev) begin
            sh0 <= {1'b1, sh0[7:1]};
            sh1 <= {1'b1, sh1[7:1]};
        end
        pclk_prev <= pad_clk;
    end

    assign pad_data = {sh1[0], sh0[0]};

    // Scan-timing monitor; cyc equals rising edges since reset release.
    int   cyc = 0;
    int   first_rise = 0;
    int   latch_len = 0;
    int   pulses = 0;
    int   hi_len = 0;
    logic width_bad = 1'b0;
    logic overlap = 1'b0;
    logic prev_latch = 1'b0;
    logic prev_clk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; first_rise = 0; latch_len = 0; pulses = 0; hi_len = 0;
            width_bad = 1'b0; overlap = 1'b0; prev_latch = 1'b0; prev_clk = 1'b0;
        end else begin
            cyc++;
            if (pad_latch && pad_clk) overlap = 1'b1;
            if (pad_latch && !prev_latch && first_rise == 0) first_rise = cyc;
            if (first_rise != 0 && cyc < first_rise + POLL) begin
                if (pad_latch) latch_len++;
                if (pad_clk && !prev_clk) pulses++;
            end
            if (pad_clk) begin
                hi_len++;
            end else begin
                if (prev_clk && hi_len != HALF) width_bad = 1'b1;
                hi_len = 0;
            end
            prev_latch = pad_latch;
            prev_clk = pad_clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        cpu_addr = addr; cpu_wdata = data; cpu_rnw = 1'b0; cpu_cyc = 1'b1;
        @(negedge clk);
        cpu_cyc = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data);
        @(negedge clk);
        cpu_addr = addr; cpu_rnw = 1'b1; cpu_cyc = 1'b1;
        @(negedge clk);
        cpu_cyc = 1'b0;
        check("rd_valid", 32'(cpu_rd_valid), 32'd1);
        data = cpu_rdata;
    endtask

    logic [7:0] rd;
    logic [7:0] exp_seq [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40,
                                 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_latch", 32'(pad_latch), 32'd0);
        check("rst_strobe", 32'(strobe_dbg), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'h00);

        // Reset asserted in the middle of a latch pulse.
        #1 rst = 1'b0;
        for (int i = 0; i < 2 * POLL && !pad_latch; i++) @(negedge clk);
        check("latch_seen", 32'(pad_latch), 32'd1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_latch", 32'(pad_latch), 32'd0);
        check("midrst_pclk", 32'(pad_clk), 32'd0);
        check("midrst_valid", 32'(cpu_rd_valid), 32'd0);
        check("midrst_rdata", 32'(cpu_rdata), 32'h00);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        btn0 = 8'h09;  // A + Start
        cpu_read(16'h4016, rd);
        check("read_before_scan", 32'(rd), 32'h40);

        while (cyc < POLL + 150) @(negedge clk);
        check("first_latch_cycle", first_rise, POLL);
        check("latch_len", latch_len, LATCH);
        check("pclk_pulses", pulses, 7);
        check("pclk_width_bad", 32'(width_bad), 32'd0);
        check("latch_clk_overlap", 32'(overlap), 32'd0);

        cpu_write(16'h4016, 8'h01);
        check("strobe_set", 32'(strobe_dbg), 32'd1);
        cpu_write(16'h4016, 8'h00);
        check("strobe_clr", 32'(strobe_dbg), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cpu_read(16'h4016, rd);
            check($sformatf("seq0_read%0d", i), 32'(rd), 32'(exp_seq[i]));
        end

        // Strobe held high: A repeats.
        cpu_write(16'h4016, 8'h01);
        for (int i = 0; i < 3; i++) begin
            cpu_read(16'h4016, rd);
            check($sformatf("strobe_hold%0d", i), 32'(rd), 32'h41);
        end
        cpu_write(16'h4016, 8'h00);
        cpu_read(16'h4016, rd);
        check("release_A", 32'(rd), 32'h41);
        cpu_read(16'h4016, rd);
        check("release_B", 32'(rd), 32'h40);

        // Second scan: pad1 = Right only, pad0 = none.
        btn0 = 8'h00;
        btn1 = 8'h80;
        while (cyc < 2 * POLL + 150) @(negedge clk);
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cpu_read(16'h4017, rd);
            check($sformatf("p1_read%0d", i), 32'(rd), (i == 7) ? 32'h41 : 32'h40);
            if (i < 7) begin
                cpu_read(16'h4016, rd);
                check($sformatf("p0_inter%0d", i), 32'(rd), 32'h40);
            end
        end

        // A write to $4017 must not touch the strobe.
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 6; i++) cpu_read(16'h4017, rd);
        cpu_write(16'h4017, 8'h01);
        check("w4017_strobe", 32'(strobe_dbg), 32'd0);
        cpu_read(16'h4017, rd);
        check("w4017_read7", 32'(rd), 32'h40);
        cpu_read(16'h4017, rd);
        check("w4017_read8", 32'(rd), 32'h41);

        // Reset clears committed pad state.
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        cpu_write(16'h4016, 8'h01);
        cpu_write(16'h4016, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cpu_read(16'h4017, rd);
            check($sformatf("cleared_p1_%0d", i), 32'(rd), 32'h40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
